// File: rtl/scfifo_flex.sv
// scfifo_flex: single-clock register-array FIFO with optional first-word-fall-through read,
// programmable almost flags, occupancy count, synchronous flush and sticky error flags.
module scfifo_flex #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic                  afull,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pull,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    if (ADDR_WIDTH < 1 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1 ||
        AEMPTY_THRESH < 1 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_param
        $error("scfifo_flex: parameter out of range");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrptr, rdptr;
    logic                  pull_ok, push_ok;

    assign empty   = count == '0;
    assign full    = count == DEPTH_C;
    assign afull   = count >= AFULL_C;
    assign aempty  = count <= AEMPTY_C;
    assign pull_ok = pull & ~empty;
    // a full FIFO can still take a word when the head leaves in the same cycle
    assign push_ok = push & (~full | pull_ok);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wrptr <= wrptr + ADDR_WIDTH'(1);
            if (pull_ok) rdptr <= rdptr + ADDR_WIDTH'(1);
            count     <= count + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pull_ok};
            overflow  <= overflow | (push & ~push_ok);
            underflow <= underflow | (pull & empty);
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok && !flush) mem[wrptr] <= data_in;
    end

    if (FWFT) begin : g_fwft
        assign data_out = mem[rdptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) dout_q <= '0;
            else if (flush) dout_q <= '0;
            else if (pull_ok) dout_q <= mem[rdptr];
        end
        assign data_out = dout_q;
    end
endmodule

// File: doc/scfifo_flex.md
# scfifo_flex

Parametrised single-clock FIFO, successor to the basic synchronous FIFO used across the engine's request and response queues. Adds true power-of-two depth sizing, a selectable first-word-fall-through read mode, programmable almost-full/almost-empty flags, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. Storage is an internal register array, so the block has no external RAM dependency.

## Interface
Parameters:
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries; must be ≥ 1.
- DATA_WIDTH, 8, word width in bits.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, afull asserts when count ≥ value; must be in 1..DEPTH-1.
- AEMPTY_THRESH, 2, aempty asserts when count ≤ value; must be in 1..DEPTH-1.
- Out-of-range parameters stop elaboration with an error.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents and error flags.
- data_in  in  DATA_WIDTH  write data.
- push  in  1  write request.
- full  out  1  count == DEPTH.
- afull  out  1  count ≥ AFULL_THRESH.
- data_out  out  DATA_WIDTH  read data.
- pull  in  1  read request.
- empty  out  1  count == 0.
- aempty  out  1  count ≤ AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pull was made while empty.

## Operation
- State: wrptr and rdptr are ADDR_WIDTH bits and wrap modulo DEPTH. count is a register of ADDR_WIDTH+1 bits. The storage array is not reset.
- Pull acceptance: pull_ok = pull & !empty. A push into an empty FIFO never satisfies a pull in the same cycle.
- Push acceptance: push_ok = push & (!full | pull_ok). When full, a push is accepted only if a pull is also accepted in that cycle.
- Pointer and count update: push_ok writes mem[wrptr] and increments wrptr. pull_ok increments rdptr. count += push_ok − pull_ok, so it is unchanged when both are accepted.
- Status flags: full, afull, empty and aempty are decoded combinationally from the count register only, never from inputs.
- Error flags: overflow is set by push & !push_ok. underflow is set by pull & empty. Both hold until flush or reset.
- Flush: clears both pointers, count, overflow and underflow. In standard mode it also clears data_out to 0. Flush has priority: push and pull in the same cycle are ignored and do not set error flags.
- Standard mode (FWFT=0): data_out is a register loaded with mem[rdptr] on pull_ok and held otherwise.
- FWFT mode (FWFT=1): data_out = mem[rdptr] combinationally. It is valid whenever empty=0 and don't-care while empty.

## Timing
- Reset values: count=0, empty=1, aempty=1, full=0, afull=0, overflow=0, underflow=0. In standard mode data_out=0. Pointers are 0.
- Write to status: after push_ok at edge N, count, empty, aempty, full and afull reflect the write from edge N onward. So empty deasserts in the cycle after the push was presented.
- Read latency, standard mode: pull_ok at edge N puts the word on data_out after edge N (1 cycle).
- Read latency, FWFT mode: the head word is visible in the cycle after it is written into an empty FIFO. pull_ok at edge N advances data_out to the next word after edge N (0-cycle read).
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. count alone distinguishes full from empty.
- Reset mid-operation: all registers except storage return to their reset values immediately. Contents are discarded.

## Test plan
- Fill and drain, ADDR_WIDTH=2, FWFT=0: push 0x11..0x14 → full=1, count=4. A fifth push sets overflow=1 and count stays 4. Pull ×4 → data_out 0x11..0x14, each one cycle after its pull; then empty=1.
- FWFT read, FWFT=1: push 0xA5 into an empty FIFO → next cycle empty=0 and data_out=0xA5 with no pull. Pull → empty=1 the following cycle.
- Simultaneous push and pull:
  - When full: push 0x55 with pull → pull returns the head word, 0x55 is accepted, count stays 4, overflow stays 0.
  - When empty: push with pull → underflow=1, count=1.
- Thresholds, DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2: step count 0→16→0 and check afull exactly at count ≥ 14 and aempty exactly at count ≤ 2.
- Flush and reset:
  - With count=3 and overflow=1, flush together with push → count=0, empty=1, overflow=0, and the push is ignored.
  - Assert aresetn low mid-stream → all outputs return to their reset values asynchronously.
- Wrap stress: random push/pull for 10,000 cycles against a queue model → data order matches, count matches the model, and no spurious error flags are raised.
